// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: serialises RV32I loads/stores into little-endian
// single-byte DATA_MEM accesses, stalling the pipeline until the access completes.
module mem_stage_lsu #(
  parameter int unsigned MEM_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              req_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [MEM_AW-1:0] base_q;
  logic [31:0]       wdata_q;
  logic [2:0]        f3_q;
  logic              we_q;
  logic [1:0]        k_q;
  logic [31:0]       buf_q;

  logic              legal;
  logic              accept;
  logic              last;
  logic [1:0]        k_last;
  logic [1:0]        k_inc;
  logic [31:0]       buf_nxt;
  logic [31:0]       ext;

  // Address bits above the memory size are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:MEM_AW];

  // Legality: funct3 must exist for the direction, halves/words must be aligned.
  always_comb begin
    legal = 1'b0;
    case (req_funct3)
      3'd0:    legal = 1'b1;
      3'd1:    legal = ~req_addr[0];
      3'd2:    legal = (req_addr[1:0] == 2'b00);
      3'd4:    legal = ~req_we;
      3'd5:    legal = ~req_we & ~req_addr[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    k_last = 2'd3;
    if (f3_q[1:0] == 2'd0)      k_last = 2'd0;
    else if (f3_q[1:0] == 2'd1) k_last = 2'd1;
    k_inc = k_q + 2'd1;
    last  = (k_q == k_last);
  end

  // Buffer including the byte being read this cycle, so the final byte can be
  // extended straight into resp_rdata.
  always_comb begin
    buf_nxt = buf_q;
    buf_nxt[{k_q, 3'b000} +: 8] = mem_rdata;
    case (f3_q)
      3'd0:    ext = {{24{buf_nxt[7]}}, buf_nxt[7:0]};
      3'd1:    ext = {{16{buf_nxt[15]}}, buf_nxt[15:0]};
      3'd4:    ext = {24'd0, buf_nxt[7:0]};
      3'd5:    ext = {16'd0, buf_nxt[15:0]};
      default: ext = buf_nxt;
    endcase
  end

  // Next state and combinational handshake outputs.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    stall     = 1'b0;
    req_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        accept  = rst & req_valid & legal;
        req_err = rst & req_valid & ~legal;
        stall   = accept;
        if (accept) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        stall = rst;
        if (last) state_nxt = ST_RESP;
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Datapath: latched request, byte counter, memory port and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q     <= '0;
      wdata_q    <= '0;
      f3_q       <= '0;
      we_q       <= 1'b0;
      k_q        <= '0;
      buf_q      <= '0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            base_q    <= req_addr[MEM_AW-1:0];
            wdata_q   <= req_wdata;
            f3_q      <= req_funct3;
            we_q      <= req_we;
            k_q       <= '0;
            buf_q     <= '0;
            mem_addr  <= req_addr[MEM_AW-1:0];
            mem_we    <= req_we;
            mem_wdata <= req_wdata[7:0];
          end
        end
        ST_BUSY: begin
          if (!we_q) buf_q <= buf_nxt;
          if (last) begin
            mem_we     <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= we_q ? 32'd0 : ext;
          end else begin
            k_q       <= k_inc;
            mem_addr  <= base_q + MEM_AW'(k_inc);
            mem_wdata <= wdata_q[{k_inc, 3'b000} +: 8];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed requests push expected responses,
// a negedge monitor pops and compares whenever resp_valid or req_err appears.
module tb_mem_stage_lsu;

  localparam int unsigned MEM_AW = 8;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              stall;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              req_err;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  typedef struct {
    bit          is_err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  logic [7:0] mem [256];

  mem_stage_lsu #(.MEM_AW(MEM_AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .req_err    (req_err),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every response or error pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b1 && (resp_valid === 1'b1 || req_err === 1'b1)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: resp_valid=%b req_err=%b at cycle %0d with nothing pending",
                 resp_valid, req_err, cyc);
      end else begin
        m_e = sb.pop_front();
        chk("resp_kind(req_err)", {31'd0, req_err}, {31'd0, m_e.is_err});
        chk("resp_cycle", 32'(cyc), 32'(m_e.cyc));
        chk("resp_exclusive", {31'd0, resp_valid & req_err}, 32'd0);
        chk("stall_during_resp", {31'd0, stall}, 32'd0);
        if (!m_e.is_err) chk("resp_rdata", resp_rdata, m_e.rdata);
      end
    end
  end

  // Called and returns just after a posedge; holds the instruction for its full duration.
  task automatic do_req(input string nm, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit err, input logic [31:0] exp_rd);
    int   n;
    int   ncyc;
    int   st_cnt;
    int   we_cnt;
    exp_t e;
    n    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    ncyc = err ? 1 : n + 2;
    e.is_err = err;
    e.rdata  = exp_rd;
    e.cyc    = cyc + (err ? 0 : n + 1);
    sb.push_back(e);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    st_cnt = 0;
    we_cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (stall === 1'b1)  st_cnt++;
      if (mem_we === 1'b1) we_cnt++;
      @(posedge clk);
      #1;
    end
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    chk({nm, " stall_cycles"}, 32'(st_cnt), err ? 32'd0 : 32'(n + 1));
    chk({nm, " write_strobes"}, 32'(we_cnt), (we && !err) ? 32'(n) : 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    rst        = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
    mem[8'h08] <= 8'h78; mem[8'h09] <= 8'h56; mem[8'h0A] <= 8'h34; mem[8'h0B] <= 8'h12;
    mem[8'h0C] <= 8'h77;
    mem[8'h10] <= 8'h11; mem[8'h11] <= 8'h22; mem[8'h12] <= 8'h5A; mem[8'h13] <= 8'h5B;
    mem[8'hFC] <= 8'h01; mem[8'hFD] <= 8'h02; mem[8'hFE] <= 8'h03; mem[8'hFF] <= 8'h84;
    #3 rst = 1'b0;
    #10;
    chk("reset stall",      {31'd0, stall},      32'd0);
    chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset req_err",    {31'd0, req_err},    32'd0);
    chk("reset mem_we",     {31'd0, mem_we},     32'd0);
    chk("reset resp_rdata", resp_rdata,          32'd0);
    chk("reset mem_addr",   32'(mem_addr),       32'd0);
    chk("reset mem_wdata",  32'(mem_wdata),      32'd0);
    @(posedge clk); #1 rst = 1'b1;
    idle(2);

    do_req("lw_08", 1'b0, 3'd2, 32'h08, 32'd0, 1'b0, 32'h12345678);
    mem[8'h09] <= 8'h80;
    idle(1);
    do_req("lb_09",  1'b0, 3'd0, 32'h09, 32'd0, 1'b0, 32'hFFFFFF80);
    do_req("lbu_09", 1'b0, 3'd4, 32'h09, 32'd0, 1'b0, 32'h00000080);

    do_req("sh_0a", 1'b1, 3'd1, 32'h0A, 32'hCAFEBEEF, 1'b0, 32'd0);
    chk("sh mem[08]", 32'(mem[8'h08]), 32'h78);
    chk("sh mem[09]", 32'(mem[8'h09]), 32'h80);
    chk("sh mem[0a]", 32'(mem[8'h0A]), 32'hEF);
    chk("sh mem[0b]", 32'(mem[8'h0B]), 32'hBE);
    chk("sh mem[0c]", 32'(mem[8'h0C]), 32'h77);
    do_req("lh_0a",  1'b0, 3'd1, 32'h0A, 32'd0, 1'b0, 32'hFFFFBEEF);
    do_req("lhu_0a", 1'b0, 3'd5, 32'h0A, 32'd0, 1'b0, 32'h0000BEEF);

    do_req("err_lw_06",   1'b0, 3'd2, 32'h06, 32'd0, 1'b1, 32'd0);
    idle(1);
    do_req("err_lh_03",   1'b0, 3'd1, 32'h03, 32'd0, 1'b1, 32'd0);
    idle(1);
    do_req("err_load_f3", 1'b0, 3'd3, 32'h00, 32'd0, 1'b1, 32'd0);
    idle(1);
    do_req("err_store_f4", 1'b1, 3'd4, 32'h30, 32'hFFFFFFFF, 1'b1, 32'd0);
    chk("err store mem[30]", 32'(mem[8'h30]), 32'h30);
    idle(1);

    // Store aborted by reset after its second byte lands.
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h10;
    req_wdata  = 32'hAABBCCDD;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort stall",      {31'd0, stall},      32'd0);
    chk("abort resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort mem_we",     {31'd0, mem_we},     32'd0);
    chk("abort mem_addr",   32'(mem_addr),       32'd0);
    chk("abort mem_wdata",  32'(mem_wdata),      32'd0);
    chk("abort resp_rdata", resp_rdata,          32'd0);
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    idle(2);
    rst = 1'b1;
    chk("abort mem[10]", 32'(mem[8'h10]), 32'hDD);
    chk("abort mem[11]", 32'(mem[8'h11]), 32'hCC);
    chk("abort mem[12]", 32'(mem[8'h12]), 32'h5A);
    chk("abort mem[13]", 32'(mem[8'h13]), 32'h5B);
    idle(1);
    do_req("lw_10_after_reset", 1'b0, 3'd2, 32'h10, 32'd0, 1'b0, 32'h5B5ACCDD);

    // Back-to-back: lw is accepted in the cycle right after the sw response.
    do_req("sw_20", 1'b1, 3'd2, 32'h20, 32'h11223344, 1'b0, 32'd0);
    do_req("lw_20", 1'b0, 3'd2, 32'h20, 32'd0, 1'b0, 32'h11223344);

    do_req("lw_1fc_hi_ignored", 1'b0, 3'd2, 32'h000001FC, 32'd0, 1'b0, 32'h84030201);
    do_req("lh_1fe",            1'b0, 3'd1, 32'h000001FE, 32'd0, 1'b0, 32'hFFFF8403);
    do_req("sb_30",             1'b1, 3'd0, 32'h30, 32'h123456A5, 1'b0, 32'd0);
    chk("sb mem[31]", 32'(mem[8'h31]), 32'h31);
    do_req("lbu_30",            1'b0, 3'd4, 32'h30, 32'd0, 1'b0, 32'h000000A5);
    do_req("lb_30",             1'b0, 3'd0, 32'h30, 32'd0, 1'b0, 32'hFFFFFFA5);

    idle(4);
    chk("pending_responses", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit for the MEM stage of the 5-stage pipeline.
- Sits between the EX/MEM pipeline register and the byte-wide DATA_MEM array.
- Serialises lb/lh/lw/lbu/lhu/sb/sh/sw into single-byte accesses in little-endian order.
- Stalls the pipeline while an access is in progress, then returns sign- or zero-extended load data to the MEM/WB register.

Parameters:
- MEM_AW, 8: byte-address width of DATA_MEM. Upper request address bits are ignored.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  EX/MEM holds a memory instruction.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3. Loads: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu. Stores: 0 sb, 1 sh, 2 sw.
- req_addr  in  32  effective byte address from the ALU.
- req_wdata  in  32  store data (rs2).
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- resp_valid  out  1  one-cycle pulse: access complete.
- resp_rdata  out  32  extended load data. 0 for stores.
- req_err  out  1  one-cycle pulse: misaligned address or illegal funct3.
- mem_addr  out  MEM_AW  byte address to DATA_MEM.
- mem_we  out  1  byte write strobe, sampled by DATA_MEM on posedge clk.
- mem_wdata  out  8  byte to write.
- mem_rdata  in  8  combinational (asynchronous) read of DATA_MEM[mem_addr].

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - stall, resp_valid, req_err, mem_we go to 0; resp_rdata, mem_addr, mem_wdata go to 0.
  - Takes effect immediately, including mid-operation. Bytes already written stay written; no response is issued.
- Byte count N: 1 for funct3 0/4, 2 for 1/5, 4 for 2.
- Illegal combinations:
  - Loads with funct3 3, 6 or 7.
  - Stores with funct3 above 2.
  - Half accesses with addr[0]=1.
  - Word accesses with addr[1:0] not 0.
- States: IDLE, BUSY, RESP.
- IDLE:
  - req_valid with a legal request: latch addr, funct3, we and wdata; clear byte counter k; go to BUSY. stall=1 combinationally in this cycle.
  - req_valid with an illegal request: req_err=1 combinationally for that cycle, no memory access, stall=0, stay in IDLE.
  - mem_we=0.
- BUSY:
  - stall=1.
  - mem_addr = latched addr + k, truncated to MEM_AW bits (wraps at the top of memory).
  - Store: mem_we=1, mem_wdata = wdata[8k+7:8k].
  - Load: capture mem_rdata into byte k of the internal buffer at posedge.
  - k increments every cycle. After byte N-1, go to RESP.
- RESP:
  - resp_valid=1, stall=0.
  - resp_rdata is the buffer extended per funct3: lb/lh sign-extend from bit 7/15, lbu/lhu zero-extend, lw passes through. Stores return 0.
  - req_valid is ignored in RESP, because it still shows the finishing instruction.
  - Next state is IDLE unconditionally.
- Timing:
  - Accept-to-response latency is N+1 cycles. The response is visible on cycle N+1 after the accept cycle.
  - stall is high for N+1 consecutive cycles.
  - Throughput is one access per N+2 cycles.
- Outside BUSY: mem_we=0, mem_addr holds its last value.
- resp_rdata holds its value until the next RESP.
- Back-to-back requests: a new instruction arriving in the cycle after RESP is accepted normally.

Test Plan:
- DATA_MEM[8..11] = 78,56,34,12; lw addr 0x08 → stall high for 5 cycles, resp_valid on cycle 5, resp_rdata = 0x12345678, mem_we never high.
- DATA_MEM[9] = 0x80; lb addr 0x09 → 0xFFFFFF80 after 2 cycles; lbu addr 0x09 → 0x00000080.
- sh wdata 0xCAFEBEEF at addr 0x0A → DATA_MEM[0x0A]=EF, [0x0B]=BE, [0x08], [0x09] and [0x0C] unchanged; resp_rdata = 0.
- lw addr 0x06, then lh addr 0x03, then load funct3=3 → each gives a single req_err pulse with stall=0, no mem_we, no resp_valid.
- sw 0xAABBCCDD at addr 0x10, rst pulled low after the 2nd byte is written → outputs 0 immediately; DATA_MEM[0x10]=DD, [0x11]=CC, [0x12..0x13] unchanged; next lw addr 0x10 completes normally.
- sw 0x11223344 at 0x20 immediately followed by lw 0x20 → lw accepted the cycle after the sw RESP, returns 0x11223344; total 12 cycles.
